// File: rtl/dcache_ctrl.sv
// Direct-mapped, one-word-per-line, write-through / no-write-allocate data cache
// controller with a single-outstanding memory port.
module dcache_ctrl #(
  parameter int ADDR_W  = 30,
  parameter int INDEX_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              dc_read_req,
  input  logic              dc_write_req,
  input  logic [ADDR_W-1:0] dc_addr,
  input  logic [3:0]        dc_byte_w_en,
  input  logic [31:0]       dc_wdata,
  output logic [31:0]       dc_rdata,
  output logic              dc_rvalid,
  output logic              dc_stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata
);

  localparam int TAG_W = ADDR_W - INDEX_W;
  localparam int LINES = 1 << INDEX_W;

  typedef enum logic [1:0] {S_IDLE, S_RD_MISS, S_WR_THRU} state_t;

  state_t              r_state, w_next_state;
  logic [LINES-1:0]    r_valid;
  logic [TAG_W-1:0]    r_tag  [LINES];
  logic [31:0]         r_data [LINES];
  logic                r_kill;
  logic [31:0]         r_dc_rdata;
  logic                r_dc_rvalid;
  logic                r_mem_req, r_mem_we;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [3:0]          r_mem_be;
  logic [31:0]         r_mem_wdata;

  logic [INDEX_W-1:0]  w_req_idx, w_fill_idx;
  logic [TAG_W-1:0]    w_req_tag, w_fill_tag;
  logic                w_hit, w_start_wr, w_lookup, w_rd_hit, w_start_rd, w_fill;
  logic [31:0]         w_merged;

  assign w_req_idx  = dc_addr[INDEX_W-1:0];
  assign w_req_tag  = dc_addr[ADDR_W-1:INDEX_W];
  // The outstanding miss address lives in the mem_addr register.
  assign w_fill_idx = r_mem_addr[INDEX_W-1:0];
  assign w_fill_tag = r_mem_addr[ADDR_W-1:INDEX_W];
  assign w_hit      = r_valid[w_req_idx] && (r_tag[w_req_idx] == w_req_tag);

  // Write beats read when both are raised; flush only drops loads.
  assign w_start_wr = (r_state == S_IDLE) && dc_write_req;
  assign w_lookup   = (r_state == S_IDLE) && dc_read_req && !dc_write_req && !flush;
  assign w_rd_hit   = w_lookup && w_hit;
  assign w_start_rd = w_lookup && !w_hit;
  assign w_fill     = (r_state == S_RD_MISS) && mem_ack;

  always_comb begin
    w_merged = r_data[w_req_idx];
    for (int b = 0; b < 4; b++)
      if (dc_byte_w_en[b]) w_merged[8*b +: 8] = dc_wdata[8*b +: 8];
  end

  // NOTE: every variable driven in always_comb gets a default first so no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_start_wr)      w_next_state = S_WR_THRU;
        else if (w_start_rd) w_next_state = S_RD_MISS;
      end
      S_RD_MISS: if (mem_ack) w_next_state = S_IDLE;
      S_WR_THRU: if (mem_ack) w_next_state = S_IDLE;
      default:   w_next_state = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next_state;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid     <= '0;
      r_kill      <= 1'b0;
      r_dc_rdata  <= '0;
      r_dc_rvalid <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_be    <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_dc_rvalid <= 1'b0;
      if (w_rd_hit) begin
        r_dc_rdata  <= r_data[w_req_idx];
        r_dc_rvalid <= 1'b1;
      end
      if (w_start_rd) begin
        r_mem_req  <= 1'b1;
        r_mem_we   <= 1'b0;
        r_mem_addr <= dc_addr;
        r_mem_be   <= 4'hF;
      end
      if (w_start_wr) begin
        r_mem_req   <= 1'b1;
        r_mem_we    <= 1'b1;
        r_mem_addr  <= dc_addr;
        r_mem_be    <= dc_byte_w_en;
        r_mem_wdata <= dc_wdata;
      end
      if (r_state == S_RD_MISS) begin
        if (w_fill) begin
          r_valid[w_fill_idx] <= 1'b1;
          r_mem_req           <= 1'b0;
          r_kill              <= 1'b0;
          if (!(r_kill || flush)) begin
            r_dc_rdata  <= mem_rdata;
            r_dc_rvalid <= 1'b1;
          end
        end else if (flush) begin
          r_kill <= 1'b1;
        end
      end
      if ((r_state == S_WR_THRU) && mem_ack) r_mem_req <= 1'b0;
    end
  end

  // NOTE: tag and data arrays carry no reset; the valid bits alone make stale contents harmless.
  always_ff @(posedge clk) begin
    if (w_fill) begin
      r_tag[w_fill_idx]  <= w_fill_tag;
      r_data[w_fill_idx] <= mem_rdata;
    end else if (w_start_wr && w_hit) begin
      r_data[w_req_idx] <= w_merged;
    end
  end

  assign dc_stall  = (r_state != S_IDLE);
  assign dc_rdata  = r_dc_rdata;
  assign dc_rvalid = r_dc_rvalid;
  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_be    = r_mem_be;
  assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: directed scenarios plus randomized
// load/store traffic against a transaction-level cache and memory model.
module tb_dcache_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        dc_read_req = 1'b0, dc_write_req = 1'b0;
  logic [29:0] dc_addr = '0;
  logic [3:0]  dc_byte_w_en = '0;
  logic [31:0] dc_wdata = '0;
  logic [31:0] dc_rdata;
  logic        dc_rvalid, dc_stall;
  logic        mem_req, mem_we;
  logic [29:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;

  dcache_ctrl #(.ADDR_W(30), .INDEX_W(4)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .dc_read_req(dc_read_req), .dc_write_req(dc_write_req),
    .dc_addr(dc_addr), .dc_byte_w_en(dc_byte_w_en), .dc_wdata(dc_wdata),
    .dc_rdata(dc_rdata), .dc_rvalid(dc_rvalid), .dc_stall(dc_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: cache contents per line, backing memory, last returned load.
  bit          m_valid [16];
  logic [25:0] m_tag   [16];
  logic [31:0] m_line  [16];
  logic [31:0] mem_img [int];
  logic [31:0] last_rdata = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [29:0] a);
    if (!mem_img.exists(int'(a))) mem_img[int'(a)] = $urandom;
    return mem_img[int'(a)];
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  function automatic bit model_hit(input logic [29:0] a);
    return m_valid[a[3:0]] && (m_tag[a[3:0]] == a[29:4]);
  endfunction

  // Busy cycles: upstream noise must be ignored while the controller stalls.
  task automatic busy_wait(input string tag, input int lat, input logic [29:0] a, input bit flush_first);
    for (int k = 0; k < lat; k++) begin
      flush        = (k == 0) ? flush_first : 1'b0;
      dc_read_req  = 1'($urandom);
      dc_write_req = 1'($urandom);
      dc_addr      = 30'($urandom);
      @(negedge clk);
      flush = 1'b0;
      check({tag, "_stall_busy"}, 32'(dc_stall), 32'd1);
      check({tag, "_req_held"}, 32'(mem_req), 32'd1);
      check({tag, "_addr_held"}, 32'(mem_addr), 32'(a));
      check({tag, "_no_rvalid_busy"}, 32'(dc_rvalid), 32'd0);
    end
    dc_read_req  = 1'b0;
    dc_write_req = 1'b0;
  endtask

  task automatic do_load(input logic [29:0] a, input int lat, input bit flush_mid, input bit flush_now);
    logic [3:0]  idx;
    logic [31:0] fillv;
    bit          hit;
    idx = a[3:0];
    hit = model_hit(a);
    dc_read_req = 1'b1;
    dc_addr     = a;
    flush       = flush_now;
    @(negedge clk);
    dc_read_req = 1'b0;
    flush       = 1'b0;
    if (flush_now) begin
      check("ld_flushed_rvalid", 32'(dc_rvalid), 32'd0);
      check("ld_flushed_req", 32'(mem_req), 32'd0);
      check("ld_flushed_stall", 32'(dc_stall), 32'd0);
      check("ld_flushed_rdata", dc_rdata, last_rdata);
      return;
    end
    if (hit) begin
      check("ld_hit_rvalid", 32'(dc_rvalid), 32'd1);
      check("ld_hit_rdata", dc_rdata, m_line[idx]);
      check("ld_hit_stall", 32'(dc_stall), 32'd0);
      check("ld_hit_no_req", 32'(mem_req), 32'd0);
      last_rdata = m_line[idx];
      return;
    end
    check("ld_miss_stall", 32'(dc_stall), 32'd1);
    check("ld_miss_req", 32'(mem_req), 32'd1);
    check("ld_miss_we", 32'(mem_we), 32'd0);
    check("ld_miss_addr", 32'(mem_addr), 32'(a));
    check("ld_miss_be", 32'(mem_be), 32'hF);
    check("ld_miss_rvalid", 32'(dc_rvalid), 32'd0);
    fillv = mem_word(a);
    busy_wait("ld", (flush_mid && lat == 0) ? 1 : lat, a, flush_mid);
    mem_ack   = 1'b1;
    mem_rdata = fillv;
    @(negedge clk);
    mem_ack   = 1'b0;
    mem_rdata = $urandom;
    m_valid[idx] = 1'b1;
    m_tag[idx]   = a[29:4];
    m_line[idx]  = fillv;
    if (!flush_mid) last_rdata = fillv;
    check("ld_fill_rvalid", 32'(dc_rvalid), flush_mid ? 32'd0 : 32'd1);
    check("ld_fill_rdata", dc_rdata, last_rdata);
    check("ld_fill_stall", 32'(dc_stall), 32'd0);
    check("ld_fill_req_drop", 32'(mem_req), 32'd0);
  endtask

  task automatic do_store(input logic [29:0] a, input logic [3:0] be, input logic [31:0] d,
                          input int lat, input bit with_read);
    logic [3:0] idx;
    idx = a[3:0];
    if (with_read) $display("note: illegal simultaneous read+write at %h, write must win", a);
    dc_write_req = 1'b1;
    dc_read_req  = with_read;
    dc_addr      = a;
    dc_byte_w_en = be;
    dc_wdata     = d;
    @(negedge clk);
    dc_write_req = 1'b0;
    dc_read_req  = 1'b0;
    check("st_stall", 32'(dc_stall), 32'd1);
    check("st_req", 32'(mem_req), 32'd1);
    check("st_we", 32'(mem_we), 32'd1);
    check("st_addr", 32'(mem_addr), 32'(a));
    check("st_be", 32'(mem_be), 32'(be));
    check("st_wdata", mem_wdata, d);
    check("st_no_rvalid", 32'(dc_rvalid), 32'd0);
    if (model_hit(a)) m_line[idx] = merge(m_line[idx], d, be);
    mem_img[int'(a)] = merge(mem_word(a), d, be);
    busy_wait("st", lat, a, 1'($urandom));
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    check("st_done_stall", 32'(dc_stall), 32'd0);
    check("st_done_req", 32'(mem_req), 32'd0);
    check("st_done_rvalid", 32'(dc_rvalid), 32'd0);
  endtask

  task automatic hit_burst(input int n);
    logic [3:0] q[$];
    logic [3:0] idx;
    for (int i = 0; i < 16; i++) if (m_valid[i]) q.push_back(4'(i));
    if (q.size() == 0) return;
    for (int i = 0; i < n; i++) begin
      idx         = q[$urandom_range(0, q.size() - 1)];
      dc_read_req = 1'b1;
      dc_addr     = {m_tag[idx], idx};
      @(negedge clk);
      check("burst_rvalid", 32'(dc_rvalid), 32'd1);
      check("burst_rdata", dc_rdata, m_line[idx]);
      check("burst_stall", 32'(dc_stall), 32'd0);
      last_rdata = m_line[idx];
    end
    dc_read_req = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rdata"}, dc_rdata, 32'd0);
    check({tag, "_rvalid"}, 32'(dc_rvalid), 32'd0);
    check({tag, "_stall"}, 32'(dc_stall), 32'd0);
    check({tag, "_req"}, 32'(mem_req), 32'd0);
    check({tag, "_we"}, 32'(mem_we), 32'd0);
    check({tag, "_addr"}, 32'(mem_addr), 32'd0);
    check({tag, "_be"}, 32'(mem_be), 32'd0);
    check({tag, "_wdata"}, mem_wdata, 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [29:0] a;
    for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
    mem_img[32'h13] = 32'hDEADBEEF;
    mem_img[32'h40] = 32'h12345678;

    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b1;
    @(negedge clk);

    do_load(30'h13, 3, 1'b0, 1'b0);
    check("cold_read_data", dc_rdata, 32'hDEADBEEF);
    do_load(30'h13, 0, 1'b0, 1'b0);
    check("reread_data", dc_rdata, 32'hDEADBEEF);
    do_store(30'h13, 4'b0011, 32'h0000CAFE, 2, 1'b0);
    do_load(30'h13, 0, 1'b0, 1'b0);
    check("merged_data", dc_rdata, 32'hDEADCAFE);
    do_store(30'h23, 4'hF, 32'h11112222, 1, 1'b0);
    do_load(30'h13, 0, 1'b0, 1'b0);
    check("alias_store_no_alloc", dc_rdata, 32'hDEADCAFE);
    do_load(30'h40, 2, 1'b1, 1'b0);
    do_load(30'h40, 0, 1'b0, 1'b0);
    check("killed_fill_cached", dc_rdata, 32'h12345678);
    do_load(30'h13, 0, 1'b0, 1'b1);
    do_store(30'h13, 4'h0, 32'hFFFFFFFF, 0, 1'b0);
    do_load(30'h13, 0, 1'b0, 1'b0);
    check("zero_be_store", dc_rdata, 32'hDEADCAFE);
    do_store(30'h13, 4'hF, 32'hA5A5A5A5, 1, 1'b1);
    do_load(30'h13, 0, 1'b0, 1'b0);
    check("write_wins", dc_rdata, 32'hA5A5A5A5);
    hit_burst(6);

    // Reset in the middle of a read miss, then a stale ack.
    dc_read_req = 1'b1;
    dc_addr     = 30'h77;
    @(negedge clk);
    dc_read_req = 1'b0;
    check("rst_miss_started", 32'(mem_req), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_all_zero("rst_mid");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    mem_ack   = 1'b1;
    mem_rdata = 32'hBAD0BAD0;
    @(negedge clk);
    mem_ack = 1'b0;
    check_all_zero("late_ack");
    for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
    last_rdata = '0;
    do_load(30'h13, 1, 1'b0, 1'b0);
    check("post_rst_refill", dc_rdata, 32'hA5A5A5A5);

    for (int n = 0; n < 150; n++) begin
      a = {26'($urandom_range(0, 3)), 4'($urandom_range(0, 7))};
      case ($urandom_range(0, 9))
        0, 1, 2:    do_store(a, 4'($urandom), $urandom, $urandom_range(0, 4), 1'b0);
        3:          do_load(a, $urandom_range(1, 4), 1'b1, 1'b0);
        4:          do_load(a, 0, 1'b0, 1'b1);
        5:          hit_burst($urandom_range(1, 4));
        default:    do_load(a, $urandom_range(0, 4), 1'b0, 1'b0);
      endcase
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
